// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner pipeline (gradient window producer and scorer).
package harris_pkg;

  localparam int GRAD_W = 16;
  localparam int WIN    = 4;

  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef grad_t [WIN-1:0][WIN-1:0] grad_win_t;

  // Line buffers hold {gx, gy}; these helpers keep the packing in one place.
  function automatic logic [2*GRAD_W-1:0] pack_grad(input grad_t gx, input grad_t gy);
    return {gx, gy};
  endfunction

  function automatic grad_t unpack_gx(input logic [2*GRAD_W-1:0] word);
    return grad_t'(word[2*GRAD_W-1:GRAD_W]);
  endfunction

  function automatic grad_t unpack_gy(input logic [2*GRAD_W-1:0] word);
    return grad_t'(word[GRAD_W-1:0]);
  endfunction

endpackage

// File: rtl/grad_line_buffer.sv
// One image line of {gx,gy}: combinational read, synchronous write.
// A read and a write to the same address in one cycle return the old word,
// which lets three instances be chained into a vertical shift of lines.
module grad_line_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  // Storage is intentionally not reset; downstream row gating hides stale data.
  logic [DW-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Write the incoming word at the current column.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/grad_window_gen.sv
// Streaming 4x4 Gx/Gy window generator feeding harris_score.
// Tracks raster position, keeps three previous lines, shifts a 4x4 window
// per accepted pixel and emits it with its top-left coordinate.
module grad_window_gen
  import harris_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int GRAD_W = 16,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic                                      in_sof,
  input  logic signed [GRAD_W-1:0]                  in_gx,
  input  logic signed [GRAD_W-1:0]                  in_gy,
  output logic signed [WIN-1:0][WIN-1:0][GRAD_W-1:0] win_gx,
  output logic signed [WIN-1:0][WIN-1:0][GRAD_W-1:0] win_gy,
  output logic                                      out_valid,
  output logic [ROW_W-1:0]                          out_row,
  output logic [COL_W-1:0]                          out_col,
  output logic                                      frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN - 1);

  logic [COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
  logic             w_last, w_win_ok;

  logic [2*GRAD_W-1:0] w_new, w_l0_rd, w_l1_rd, w_l2_rd;

  logic signed [WIN-1:0][GRAD_W-1:0]          w_colv_gx, w_colv_gy;
  logic signed [WIN-1:0][WIN-1:0][GRAD_W-1:0] r_win_gx, r_win_gy;
  logic                                       r_out_valid, r_frame_done;
  logic [ROW_W-1:0]                           r_out_row;
  logic [COL_W-1:0]                           r_out_col;

  assign w_new = {in_gx, in_gy};

  // Position of the pixel being accepted and the position that follows it.
  always_comb begin
    w_row     = r_row;
    w_col     = r_col;
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_last    = 1'b0;
    if (in_sof) begin
      w_row = '0;
      w_col = '0;
    end else begin
      w_row = r_row;
      w_col = r_col;
    end
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      if (w_row == ROW_LAST) begin
        w_row_nxt = '0;
        w_last    = 1'b1;
      end else begin
        w_row_nxt = w_row + ROW_W'(1);
      end
    end else begin
      w_col_nxt = w_col + COL_W'(1);
      w_row_nxt = w_row;
    end
    w_win_ok = (w_row >= ROW_MIN) && (w_col >= COL_MIN);
  end

  // Three chained lines: L0 = row-1, L1 = row-2, L2 = row-3.
  grad_line_buffer #(.DEPTH(IMG_W), .DW(2*GRAD_W)) u_line0 (
    .clk(clk), .i_we(in_valid), .i_addr(w_col), .i_wdata(w_new),   .o_rdata(w_l0_rd)
  );
  grad_line_buffer #(.DEPTH(IMG_W), .DW(2*GRAD_W)) u_line1 (
    .clk(clk), .i_we(in_valid), .i_addr(w_col), .i_wdata(w_l0_rd), .o_rdata(w_l1_rd)
  );
  grad_line_buffer #(.DEPTH(IMG_W), .DW(2*GRAD_W)) u_line2 (
    .clk(clk), .i_we(in_valid), .i_addr(w_col), .i_wdata(w_l1_rd), .o_rdata(w_l2_rd)
  );

  // New right-hand window column: oldest line on top, current pixel at the bottom.
  always_comb begin
    w_colv_gx    = '0;
    w_colv_gy    = '0;
    w_colv_gx[0] = w_l2_rd[2*GRAD_W-1:GRAD_W];
    w_colv_gy[0] = w_l2_rd[GRAD_W-1:0];
    w_colv_gx[1] = w_l1_rd[2*GRAD_W-1:GRAD_W];
    w_colv_gy[1] = w_l1_rd[GRAD_W-1:0];
    w_colv_gx[2] = w_l0_rd[2*GRAD_W-1:GRAD_W];
    w_colv_gy[2] = w_l0_rd[GRAD_W-1:0];
    w_colv_gx[3] = in_gx;
    w_colv_gy[3] = in_gy;
  end

  // Raster counters advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (in_valid) begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end else begin
      r_row <= r_row;
      r_col <= r_col;
    end
  end

  // Window shift register and registered strobes/coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_gx     <= '0;
      r_win_gy     <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < WIN; r++) begin
        for (int k = 0; k < WIN - 1; k++) begin
          r_win_gx[r][k] <= r_win_gx[r][k+1];
          r_win_gy[r][k] <= r_win_gy[r][k+1];
        end
        r_win_gx[r][WIN-1] <= w_colv_gx[r];
        r_win_gy[r][WIN-1] <= w_colv_gy[r];
      end
      r_out_valid  <= w_win_ok;
      r_frame_done <= w_last;
      if (w_win_ok) begin
        r_out_row <= w_row - ROW_MIN;
        r_out_col <= w_col - COL_MIN;
      end else begin
        r_out_row <= r_out_row;
        r_out_col <= r_out_col;
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign win_gx     = r_win_gx;
  assign win_gy     = r_win_gy;
  assign out_valid  = r_out_valid;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_grad_window_gen.sv
// Scoreboard bench for grad_window_gen on an 8x6 image.
module tb_grad_window_gen;
  import harris_pkg::*;

  localparam int IW = 8;
  localparam int IH = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  grad_t      in_gx = '0;
  grad_t      in_gy = '0;
  grad_win_t  win_gx, win_gy;
  logic       out_valid, frame_done;
  logic [2:0] out_row, out_col;

  typedef struct {
    int        row;
    int        col;
    int        base;
    grad_win_t gx;
    grad_win_t gy;
  } exp_t;

  exp_t q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   win_cnt = 0;
  int   fd_cnt = 0;
  logic acc_prev = 1'b0;

  always #5 clk = ~clk;

  grad_window_gen #(.IMG_W(IW), .IMG_H(IH), .GRAD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_gx(in_gx), .in_gy(in_gy), .win_gx(win_gx), .win_gy(win_gy),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int base, input int row, input int col);
    return base + row * 16 + col;
  endfunction

  // Drive one pixel; record the window it should complete.
  task automatic drive_pix(input int row, input int col, input int base, input logic sof);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_gx    = grad_t'(pix(base, row, col));
    in_gy    = grad_t'(-pix(base, row, col));
    if (row >= 3 && col >= 3) begin
      e.row  = row - 3;
      e.col  = col - 3;
      e.base = base;
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) begin
          e.gx[r][k] = grad_t'(pix(base, e.row + r, e.col + k));
          e.gy[r][k] = grad_t'(-pix(base, e.row + r, e.col + k));
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input logic sof, input logic gapped);
    for (int p = 0; p < IW * IH; p++) begin
      drive_pix(p / IW, p % IW, base, sof && (p == 0));
      if (gapped) idle(1);
    end
  endtask

  task automatic finish_test(input string tag, input int w0, input int f0,
                             input int exp_w, input int exp_f);
    idle(4);
    check({tag, "_sb_empty"}, 256'(q.size()), 256'(0));
    check({tag, "_windows"}, 256'(win_cnt - w0), 256'(exp_w));
    check({tag, "_frame_done"}, 256'(fd_cnt - f0), 256'(exp_f));
  endtask

  // Remember whether the previous edge accepted a pixel.
  always @(posedge clk) acc_prev <= in_valid;

  // Compare every emitted window against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (out_valid) begin
        win_cnt++;
        if (!acc_prev) check("idle_valid", 256'(1), 256'(0));
        if (q.size() == 0) begin
          check("sb_unexpected", 256'(1), 256'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_row", 256'(out_row), 256'(e.row));
          check("out_col", 256'(out_col), 256'(e.col));
          check("win_gx", win_gx, e.gx);
          check("win_gy", win_gy, e.gy);
          if (e.base == 0 && e.row == 0 && e.col == 0) begin
            check("first_gx00", 256'($signed(win_gx[0][0])), 256'(0));
            check("first_gx33", 256'($signed(win_gx[3][3])), 256'(51));
            check("first_gy33", 256'($signed(win_gy[3][3])), 256'(-51));
          end
          if (e.base == 0 && e.row == 2 && e.col == 4) begin
            check("w24_gx12", 256'($signed(win_gx[1][2])), 256'(54));
            check("w24_gx30", 256'($signed(win_gx[3][0])), 256'(84));
          end
        end
      end
    end
  end

  initial begin
    int w0, f0;
    idle(3);
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_win_gx", win_gx, 256'(0));
    check("rst_row", 256'(out_row), 256'(0));
    check("rst_done", 256'(frame_done), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Continuous frame, sof on the first pixel.
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(0, 1'b1, 1'b0);
    finish_test("cont", w0, f0, 15, 1);

    // Same image with an idle cycle after every pixel.
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(0, 1'b1, 1'b1);
    finish_test("gap", w0, f0, 15, 1);

    // Resync: sof at pixel index 20 of a partially sent frame.
    w0 = win_cnt; f0 = fd_cnt;
    for (int p = 0; p < 20; p++) drive_pix(p / IW, p % IW, 500, p == 0);
    send_frame(0, 1'b1, 1'b0);
    finish_test("sof", w0, f0, 15, 1);

    // Reset in the middle of row 4, then a frame without sof.
    w0 = win_cnt; f0 = fd_cnt;
    for (int p = 0; p < 4 * IW + 3; p++) drive_pix(p / IW, p % IW, 300, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", 256'(out_valid), 256'(0));
    check("mid_rst_win_gx", win_gx, 256'(0));
    check("mid_rst_win_gy", win_gy, 256'(0));
    check("mid_rst_col", 256'(out_col), 256'(0));
    check("mid_rst_sb", 256'(q.size()), 256'(0));
    idle(2);
    rst_n = 1'b1;
    send_frame(0, 1'b0, 1'b0);
    finish_test("rst", w0, f0, 20, 1);

    // Two back-to-back frames, second with distinct data and no sof.
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(1000, 1'b1, 1'b0);
    send_frame(2000, 1'b0, 1'b0);
    finish_test("b2b", w0, f0, 30, 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
